// File: rtl/mealy_stream_arbiter.sv
// Round-robin arbiter that serialises LEN-bit requester patterns onto a shared
// Mealy detector and returns the per-bit detector responses as a mask and hit count.
module mealy_stream_arbiter #(
   parameter  int unsigned N_REQ = 4,
   parameter  int unsigned LEN   = 8,
   localparam int unsigned IDW   = $clog2(N_REQ),
   localparam int unsigned CW    = $clog2(LEN + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*LEN-1:0]   req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   det_reset,
   output logic                   ctl_out,
   input  logic                   det_out,
   output logic                   rsp_valid,
   output logic [IDW-1:0]         rsp_id,
   output logic [LEN-1:0]         rsp_mask,
   output logic [CW-1:0]          rsp_hits,
   output logic                   busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q;
   logic [N_REQ-1:0] req_ready_q, req_ready_d;
   logic [IDW-1:0]   gnt_id_q;
   logic [IDW-1:0]   job_id_q;
   logic [LEN-1:0]   sr_q;
   logic [LEN-1:0]   acc_q;
   logic [CW-1:0]    hits_q;
   logic [CW-1:0]    cnt_q;
   logic [IDW-1:0]   rsp_id_q;
   logic [LEN-1:0]   rsp_mask_q;
   logic [CW-1:0]    rsp_hits_q;

   logic             arb_en;
   logic             gnt_hit;
   logic [IDW-1:0]   gnt_idx;
   int unsigned      idx;
   logic             last_bit;

   assign last_bit = (cnt_q == CW'(LEN - 1));

   // Grant is registered: it is decided in DONE (or an empty IDLE) so that the
   // pulse lands in the following IDLE cycle, keeping outputs flop-driven while
   // still giving LEN+2 job spacing.
   assign arb_en = (state_q == DONE) || ((state_q == IDLE) && (req_ready_q == '0));

   always_comb begin
      gnt_hit = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = (32'(rr_ptr_q) + k) % N_REQ;
         if (!gnt_hit && req_valid[IDW'(idx)]) begin
            gnt_hit = 1'b1;
            gnt_idx = IDW'(idx);
         end
      end
      req_ready_d = '0;
      if (arb_en && gnt_hit) begin
         req_ready_d = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_ready_q != '0) state_d = SHIFT;
         SHIFT:   if (last_bit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q    <= '0;
         req_ready_q <= '0;
         gnt_id_q    <= '0;
         job_id_q    <= '0;
         sr_q        <= '0;
         acc_q       <= '0;
         hits_q      <= '0;
         cnt_q       <= '0;
         rsp_id_q    <= '0;
         rsp_mask_q  <= '0;
         rsp_hits_q  <= '0;
      end else begin
         req_ready_q <= req_ready_d;
         if (arb_en && gnt_hit) begin
            gnt_id_q <= gnt_idx;
         end
         case (state_q)
            IDLE: begin
               if (req_ready_q != '0) begin
                  sr_q     <= req_data[32'(gnt_id_q)*LEN +: LEN];
                  acc_q    <= '0;
                  hits_q   <= '0;
                  cnt_q    <= '0;
                  job_id_q <= gnt_id_q;
                  rr_ptr_q <= (gnt_id_q == IDW'(N_REQ - 1)) ? '0 : gnt_id_q + IDW'(1);
               end
            end
            SHIFT: begin
               sr_q   <= {sr_q[LEN-2:0], 1'b0};
               acc_q  <= {acc_q[LEN-2:0], det_out};
               hits_q <= hits_q + CW'(det_out);
               cnt_q  <= cnt_q + CW'(1);
               if (last_bit) begin
                  rsp_id_q   <= job_id_q;
                  rsp_mask_q <= {acc_q[LEN-2:0], det_out};
                  rsp_hits_q <= hits_q + CW'(det_out);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      req_ready = req_ready_q;
      ctl_out   = (state_q == SHIFT) & sr_q[LEN-1];
      det_reset = (state_q != SHIFT);
      busy      = (state_q != IDLE);
      rsp_valid = (state_q == DONE);
      rsp_id    = rsp_id_q;
      rsp_mask  = rsp_mask_q;
      rsp_hits  = rsp_hits_q;
   end

endmodule

// File: tb/tb_mealy_stream_arbiter.sv
// Scoreboard bench for mealy_stream_arbiter with a stand-in detector that either
// echoes control or flags two consecutive ones (cleared by det_reset).
module tb_mealy_stream_arbiter;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned LEN   = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        det_reset, ctl_out, det_out;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_mask;
   logic [3:0]  rsp_hits;
   logic        busy;

   mealy_stream_arbiter #(.N_REQ(N_REQ), .LEN(LEN)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .det_reset(det_reset), .ctl_out(ctl_out),
      .det_out(det_out), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_mask(rsp_mask), .rsp_hits(rsp_hits), .busy(busy)
   );

   always #5 clk = ~clk;

   logic det_mode = 1'b0;
   logic det_prev_q;
   always @(posedge clk) det_prev_q <= det_reset ? 1'b0 : ctl_out;
   assign det_out = det_mode ? (ctl_out & det_prev_q) : ctl_out;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] mask;
      logic [3:0] hits;
      logic [7:0] pat;
   } exp_t;

   int   exp_gnt[$];
   exp_t exp_rsp[$];

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int n_gnt = 0, n_rsp = 0;
   int gnt_cyc = 0, last_gnt_cyc = -1;
   int det_low = 0;
   bit spacing_en = 1'b0;
   logic [7:0] ctl_seq = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] det_model(input logic [7:0] pat, input logic mode);
      logic       prev = 1'b0;
      logic [7:0] m = '0;
      for (int i = 7; i >= 0; i--) begin
         m    = {m[6:0], mode ? (pat[i] & prev) : pat[i]};
         prev = pat[i];
      end
      return m;
   endfunction

   task automatic push_job(input int id, input logic [7:0] pat);
      exp_t e;
      e.id   = 2'(id);
      e.pat  = pat;
      e.mask = det_model(pat, det_mode);
      e.hits = 4'($countones(e.mask));
      exp_gnt.push_back(id);
      exp_rsp.push_back(e);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      int   g;
      if (req_ready != 4'b0000) begin
         if (exp_gnt.size() == 0) begin
            chk("unexpected_grant", 32'(req_ready), 32'h0);
         end else begin
            g = exp_gnt.pop_front();
            chk("grant", 32'(req_ready), 32'(1) << g);
         end
         chk("busy_at_grant", 32'(busy), 32'h0);
         if (spacing_en && last_gnt_cyc >= 0) chk("grant_spacing", 32'(cyc - last_gnt_cyc), LEN + 2);
         last_gnt_cyc = cyc;
         gnt_cyc = cyc;
         det_low = 0;
         ctl_seq = '0;
         n_gnt++;
      end
      if (det_reset === 1'b0) begin
         det_low++;
         ctl_seq = {ctl_seq[6:0], ctl_out};
      end
      if (rsp_valid === 1'b1) begin
         if (exp_rsp.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
         end else begin
            e = exp_rsp.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_mask", 32'(rsp_mask), 32'(e.mask));
            chk("rsp_hits", 32'(rsp_hits), 32'(e.hits));
            chk("ctl_sequence", 32'(ctl_seq), 32'(e.pat));
            chk("det_reset_low_cycles", 32'(det_low), LEN);
            chk("rsp_latency", 32'(cyc - gnt_cyc), LEN + 1);
            chk("busy_at_rsp", 32'(busy), 32'h1);
         end
         n_rsp++;
      end
   end

   task automatic wait_gnt(input int target);
      int t = 0;
      while (n_gnt < target && t < 200) begin
         @(negedge clk); #1;
         t++;
      end
      if (n_gnt < target) chk("grant_timeout", 32'(n_gnt), 32'(target));
   endtask

   task automatic wait_rsp(input int target);
      int t = 0;
      while (n_rsp < target && t < 200) begin
         @(negedge clk); #1;
         t++;
      end
      if (n_rsp < target) chk("rsp_timeout", 32'(n_rsp), 32'(target));
   endtask

   task automatic run_single(input int id, input logic [7:0] pat);
      int g0 = n_gnt;
      int r0 = n_rsp;
      req_data[id*8 +: 8] = pat;
      push_job(id, pat);
      req_valid[id] = 1'b1;
      wait_gnt(g0 + 1);
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      wait_rsp(r0 + 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int g0, r0;
      reset     = 1'b1;
      req_valid = 4'b0001;
      req_data  = '0;

      // Reset state, with a request held during reset (must not be granted)
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_ctl_out", 32'(ctl_out), 32'h0);
      chk("rst_det_reset", 32'(det_reset), 32'h1);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_id", 32'(rsp_id), 32'h0);
      chk("rst_rsp_mask", 32'(rsp_mask), 32'h0);
      chk("rst_rsp_hits", 32'(rsp_hits), 32'h0);
      req_valid = '0;
      @(posedge clk); #1;
      reset = 1'b0;

      // Single job from requester 0
      run_single(0, 8'hB2);

      // Round robin with all requesters held from reset release
      req_data = {8'h96, 8'hC3, 8'h5A, 8'h3C};
      reset = 1'b1;
      req_valid = 4'b1111;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) push_job(i % 4, req_data[(i % 4)*8 +: 8]);
      g0 = n_gnt; r0 = n_rsp;
      spacing_en = 1'b1;
      last_gnt_cyc = -1;
      reset = 1'b0;
      wait_gnt(g0 + 5);
      @(posedge clk); #1;
      req_valid = '0;
      spacing_en = 1'b0;
      wait_rsp(r0 + 5);

      // Pointer wrap: serve 2, then 1 and 3 pending -> 3 first
      run_single(2, 8'hE1);
      req_data[3*8 +: 8] = 8'h4D;
      req_data[1*8 +: 8] = 8'h1F;
      push_job(3, 8'h4D);
      push_job(1, 8'h1F);
      g0 = n_gnt; r0 = n_rsp;
      req_valid = 4'b1010;
      wait_gnt(g0 + 1);
      @(posedge clk); #1;
      req_valid[3] = 1'b0;
      wait_gnt(g0 + 2);
      @(posedge clk); #1;
      req_valid = '0;
      wait_rsp(r0 + 2);

      // Reset mid-job: the aborted job must produce no response
      req_data[1*8 +: 8] = 8'hAA;
      exp_gnt.push_back(1);
      g0 = n_gnt; r0 = n_rsp;
      req_valid = 4'b0010;
      wait_gnt(g0 + 1);
      @(posedge clk); #1;
      req_valid = 4'b0101;
      req_data[0*8 +: 8] = 8'h71;
      req_data[2*8 +: 8] = 8'hC8;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk); #1;
      chk("midrst_ctl_out", 32'(ctl_out), 32'h0);
      chk("midrst_det_reset", 32'(det_reset), 32'h1);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("midrst_rsp_mask", 32'(rsp_mask), 32'h0);
      chk("midrst_rsp_hits", 32'(rsp_hits), 32'h0);
      push_job(0, 8'h71);
      push_job(2, 8'hC8);
      @(posedge clk); #1;
      reset = 1'b0;
      wait_gnt(g0 + 2);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      wait_gnt(g0 + 3);
      @(posedge clk); #1;
      req_valid = '0;
      wait_rsp(r0 + 2);

      // Two-ones detector: each job must start from the detector's reset state
      det_mode = 1'b1;
      run_single(0, 8'hFF);
      run_single(0, 8'h00);
      run_single(0, 8'h81);
      run_single(0, 8'hB6);
      det_mode = 1'b0;

      // Idle for 50 cycles
      g0 = n_gnt; r0 = n_rsp;
      repeat (50) begin
         @(negedge clk); #1;
         chk("idle_busy", 32'(busy), 32'h0);
         chk("idle_ctl_out", 32'(ctl_out), 32'h0);
         chk("idle_det_reset", 32'(det_reset), 32'h1);
         chk("idle_req_ready", 32'(req_ready), 32'h0);
         chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
      end
      chk("idle_grants", 32'(n_gnt - g0), 32'h0);
      chk("idle_rsps", 32'(n_rsp - r0), 32'h0);

      chk("grants_outstanding", 32'(exp_gnt.size()), 32'h0);
      chk("rsps_outstanding", 32'(exp_rsp.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
